// File: rtl/truth_table_checker.sv
// Sequential truth-table sweeper: drives every input vector to a combinational
// gate, samples its output, and reports pass / error count / first failing vector.
module truth_table_checker #(
  parameter int                   N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0] EXP    = 4'b1000,
  parameter int                   SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_idx
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

  localparam logic [N_IN-1:0] LAST_IDX   = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [3:0]      hold_cnt;
  logic            exp_bit;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // The vector index register drives the gate directly, so stim is glitch-free.
  assign stim = idx;

  always_comb begin
    exp_bit  = EXP[idx];
    // X/Z on the gate output compares as a mismatch in simulation.
    mismatch = (dut_y !== exp_bit);
    err_next = err_count + {{N_IN{1'b0}}, mismatch};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge value of its neighbours regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: everything here is a small flop, so all of it is cleared on reset;
    // there is no memory array that would need to be left unreset.
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= HOLD;
            idx        <= '0;
            hold_cnt   <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == SETTLE_CNT) state <= SAMPLE;
          else                        hold_cnt <= hold_cnt + 4'd1;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_next;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
            end
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            // err_next already includes this final comparison.
            pass  <= (err_next == '0);
          end else begin
            state    <= HOLD;
            idx      <= idx + 1'b1;
            hold_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential stimulus/response engine for lab gate exercises. It drives every input vector to a combinational device under test, samples the DUT output and compares it against an expected truth table.
- It reports the result as a pass flag, an error count and the first failing vector.
- It sits opposite a gate module such as a 2-input AND: it drives the gate inputs and receives its output. This replaces hand-written initial-block stimulus in lab benches and FPGA demo tops.

Parameters:
- N_IN, 2: number of DUT inputs; vectors swept 0 .. 2^N_IN-1.
- EXP, 4'b1000: expected output; bit i is the expected y for stim == i (default is the AND table); width 2^N_IN.
- SETTLE, 1: extra hold cycles per vector before sampling; legal 0..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- stim  output  N_IN  registered vector to DUT inputs; stim[N_IN-1] is the MSB (e.g. a), stim[0] the LSB (e.g. b).
- dut_y  input  1  DUT output.
- busy  output  1  high from the edge accepting start until the edge entering DONE.
- done  output  1  one-cycle pulse on entry to DONE.
- pass  output  1  valid while in DONE: 1 iff err_count == 0; 0 otherwise.
- err_count  output  N_IN+1  number of mismatching vectors in the current/last sweep.
- fail_valid  output  1  at least one mismatch seen this sweep.
- fail_idx  output  N_IN  vector index of the first mismatch; 0 when fail_valid = 0.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state = IDLE; stim, busy, done, pass, err_count, fail_valid, fail_idx, idx and the hold counter all cleared to 0. Deassertion is synchronous to the next clk edge.
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE or DONE with start = 1 at edge E:
  - Go to HOLD; idx = 0; stim = 0; hold counter = 0.
  - Clear err_count, fail_valid, fail_idx and pass; busy = 1.
- HOLD:
  - If hold counter == SETTLE, go to SAMPLE.
  - Otherwise increment the counter.
  - With SETTLE = 0, HOLD lasts exactly one cycle.
- SAMPLE, at the edge leaving SAMPLE:
  - Compare dut_y to EXP[idx]. A mismatch is dut_y != EXP[idx]; in simulation an X/Z on dut_y also counts as a mismatch.
  - On mismatch: err_count += 1. If fail_valid = 0, then fail_idx = idx and fail_valid = 1.
  - If idx == 2^N_IN-1: go to DONE; done = 1 for that cycle; busy = 0; pass = (final err_count == 0), including the last comparison.
  - Otherwise: idx += 1; stim = idx+1 on the same edge; hold counter = 0; go to HOLD.
- Timing:
  - Each vector is held for SETTLE+2 cycles.
  - dut_y is sampled SETTLE+1 cycles after stim changes.
  - done rises (2^N_IN)*(SETTLE+2) cycles after the start edge.
  - Defaults give 4*3 = 12 cycles.
- DONE:
  - stim holds the last vector.
  - Results hold until the next start or reset.
  - done deasserts after one cycle.
- err_count cannot overflow: its maximum is 2^N_IN, which fits N_IN+1 bits.
- start while busy: ignored, with no effect on idx, counters or results.
- start held high continuously: a new sweep begins on the cycle after DONE is entered. The done pulse still occurs and the results are then cleared.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. No done pulse and no partial result is retained.
- dut_y is ignored outside SAMPLE.

Test Plan:
- Defaults, DUT = correct AND, start pulse -> stim sequence 00,01,10,11 with 3 cycles each; done at cycle 12; pass = 1, err_count = 0, fail_valid = 0.
- Defaults, DUT = OR gate -> mismatches at idx 1 and 2; err_count = 2, fail_idx = 1, fail_valid = 1, pass = 0.
- Defaults, DUT output stuck-at-0 -> err_count = 1, fail_idx = 3, pass = 0; then a second sweep with a correct DUT -> results cleared; pass = 1, err_count = 0.
- SETTLE = 3, N_IN = 3, EXP = 8'h80 (3-input AND), correct DUT -> each vector held 5 cycles; done 40 cycles after start; pass = 1.
- rst_n pulsed low asynchronously (between edges) during the third vector -> all outputs 0 immediately; no done pulse; a later start runs a full clean sweep.
- start re-pulsed at cycles 2 and 7 of a sweep -> ignored; done still at cycle 12; results identical to a single-start run.
